// File: rtl/alu_issue_queue.sv
// Instruction FIFO that feeds an external combinational ALU one word at a time
// and holds each captured result until the consumer accepts it.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              instr_in,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic [11:0]              alu_in,
  input  logic [3:0]               alu_sum,
  output logic [3:0]               res_out,
  output logic [3:0]               res_opcode,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic        push;
  logic        pop;
  logic        not_empty;

  // Handshake decode; both push and pop look only at the occupancy at cycle start.
  always_comb begin
    not_empty   = (count != CNT_ZERO);
    instr_ready = (count != FULL_CNT);
    push        = instr_valid && instr_ready;
    case (state)
      IDLE:    pop = not_empty;
      HOLD:    pop = not_empty && res_ready;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr_in;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Issue sequencer: one instruction in flight, result held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_in     <= 12'h000;
      res_out    <= 4'h0;
      res_opcode <= 4'h0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_in <= mem[rd_ptr];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          res_out    <= alu_sum;
          res_opcode <= alu_in[11:8];
          res_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_in <= mem[rd_ptr];
              state  <= ISSUE;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomised and directed bench for alu_issue_queue; a queue-based model of the
// FIFO plus a single in-flight slot predicts every output on every cycle.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] alu_in;
  logic [3:0]  alu_sum;
  logic [3:0]  res_out;
  logic [3:0]  res_opcode;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  // Model state: waiting words, the word currently issued, and whether its result is out.
  logic [11:0] m_q[$];
  logic [11:0] m_slot;
  bit          m_full;
  bit          m_res;
  logic [7:0]  drained[$];

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_in(alu_in), .alu_sum(alu_sum),
    .res_out(res_out), .res_opcode(res_opcode), .res_valid(res_valid),
    .res_ready(res_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [11:0] w);
    case (w[11:8])
      4'h0:    return w[7:4] ^ w[3:0];
      4'h1:    return w[7:4] + w[3:0];
      4'h2:    return w[7:4] - w[3:0];
      4'h3:    return w[7:4];
      default: return 4'h0;
    endcase
  endfunction

  assign alu_sum = ref_alu(alu_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_full = 1'b0;
    m_res  = 1'b0;
  endtask

  // Advance the model across the coming edge using the inputs now applied.
  task automatic model_step();
    int  sz;
    bit  do_push;
    bit  consume;
    if (!rst_n) begin
      model_clear();
    end else begin
      sz      = m_q.size();
      do_push = instr_valid && (sz != DEPTH);
      consume = m_full && m_res && res_ready;
      if (consume) drained.push_back({res_opcode, res_out});
      if ((!m_full || consume) && sz != 0) begin
        m_slot = m_q.pop_front();
        m_full = 1'b1;
        m_res  = 1'b0;
      end else if (consume) begin
        m_full = 1'b0;
        m_res  = 1'b0;
      end else if (m_full) begin
        m_res = 1'b1;
      end
      if (do_push) m_q.push_back(instr_in);
    end
  endtask

  task automatic compare();
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, (m_q.size() != DEPTH)});
    chk("count", {29'd0, count}, m_q.size());
    chk("res_valid", {31'd0, res_valid}, {31'd0, (m_full && m_res)});
    if (m_full) chk("alu_in", {20'd0, alu_in}, {20'd0, m_slot});
    if (m_full && m_res) begin
      chk("res_out", {28'd0, res_out}, {28'd0, ref_alu(m_slot)});
      chk("res_opcode", {28'd0, res_opcode}, {28'd0, m_slot[11:8]});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic single_op(input logic [11:0] w, input logic [3:0] eo, input logic [3:0] eop);
    res_ready   = 1'b1;
    instr_valid = 1'b1;
    instr_in    = w;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("lat_alu_in", {20'd0, alu_in}, {20'd0, w});
    chk("lat_valid_early", {31'd0, res_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, res_valid}, 32'd1);
    chk("lat_res_out", {28'd0, res_out}, {28'd0, eo});
    chk("lat_res_op", {28'd0, res_opcode}, {28'd0, eop});
    tick();
  endtask

  logic [11:0] fill_words [6];
  logic [7:0]  drain_exp  [6];

  initial begin
    int base;
    rst_n = 1'b0; instr_valid = 1'b0; instr_in = 12'h000; res_ready = 1'b0;
    model_clear();
    tick();
    tick();
    chk("rst_alu_in", {20'd0, alu_in}, 32'h000);
    chk("rst_res_out", {28'd0, res_out}, 32'h0);
    chk("rst_res_op", {28'd0, res_opcode}, 32'h0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    single_op(12'h134, 4'h7, 4'h1);
    single_op(12'h225, 4'hD, 4'h2);
    single_op(12'h0A5, 4'hF, 4'h0);
    single_op(12'h3C7, 4'hC, 4'h3);
    single_op(12'h9FF, 4'h0, 4'h9);

    // Fill with the consumer stalled; the sixth offer must be refused.
    fill_words = '{12'h112, 12'h123, 12'h134, 12'h145, 12'h156, 12'h167};
    drain_exp  = '{8'h13, 8'h15, 8'h17, 8'h19, 8'h1B, 8'h1F};
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1;
      instr_in    = fill_words[i];
      tick();
    end
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, instr_ready}, 32'd0);
    instr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_res_out", {28'd0, res_out}, 32'h3);
      chk("hold_res_op", {28'd0, res_opcode}, 32'h1);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
    end
    base        = drained.size();
    res_ready   = 1'b1;
    instr_valid = 1'b1;
    instr_in    = 12'h178;
    tick();
    chk("popfull_count", {29'd0, count}, 32'd3);
    tick();
    chk("push_after_pop", {29'd0, count}, 32'd4);
    instr_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("drain_len", drained.size() - base, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < drained.size()) chk("drain_order", {24'd0, drained[base+i]}, {24'd0, drain_exp[i]});
    end

    // Reset while a result is held and three words wait.
    res_ready = 1'b0;
    fill_words = '{12'h412, 12'h523, 12'h034, 12'h1AB, 12'h000, 12'h000};
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      instr_in    = fill_words[i];
      tick();
    end
    instr_valid = 1'b0;
    tick();
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    chk("pre_rst_valid", {31'd0, res_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async_count", {29'd0, count}, 32'd0);
    chk("async_valid", {31'd0, res_valid}, 32'd0);
    chk("async_alu_in", {20'd0, alu_in}, 32'h000);
    chk("async_res_out", {28'd0, res_out}, 32'h0);
    chk("async_res_op", {28'd0, res_opcode}, 32'h0);
    chk("async_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_quiet", {31'd0, res_valid}, 32'd0);
    end

    // Random traffic with stall phases and occasional mid-cycle resets.
    for (int i = 0; i < 1200; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_in    = 12'($urandom);
      if (((i / 100) % 2) == 1) res_ready = ($urandom_range(0, 4) == 0);
      else                      res_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; assertion SHALL clear state immediately, independent of clk.
REQ-004 instr_in  input  12  instruction word: [11:8] opcode, [7:4] operand a, [3:0] operand b.
REQ-005 instr_valid  input  1  producer has an instruction on instr_in.
REQ-006 instr_ready  output  1  queue can accept; SHALL equal (count != DEPTH).
REQ-007 alu_in  output  12  registered instruction driven to the combinational ALU's 12-bit input.
REQ-008 alu_sum  input  4  combinational 4-bit ALU result for alu_in.
REQ-009 res_out  output  4  captured ALU result.
REQ-010 res_opcode  output  4  opcode of the instruction that produced res_out.
REQ-011 res_valid  output  1  res_out/res_opcode valid.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 count  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 Push SHALL occur on an edge where instr_valid && instr_ready; word written at write pointer, pointer += 1 modulo DEPTH.
REQ-015 instr_ready SHALL be computed from count at the start of the cycle; a pop in the same cycle SHALL NOT enable a push into a full FIFO.
REQ-016 Pop SHALL occur only when count != 0 at the start of the cycle; a word pushed into an empty FIFO SHALL NOT bypass to alu_in in the same cycle.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-018 Issue FSM states: IDLE, ISSUE, HOLD.
REQ-019 IDLE: if count != 0, pop head into alu_in, go ISSUE; else stay IDLE, alu_in unchanged.
REQ-020 ISSUE: capture alu_sum into res_out and alu_in[11:8] into res_opcode, set res_valid, go HOLD.
REQ-021 HOLD: while !res_ready, res_valid, res_out, res_opcode SHALL hold stable.
REQ-022 HOLD with res_ready: clear res_valid; if count != 0, pop head into alu_in and go ISSUE, else go IDLE.
REQ-023 Latency: instruction pushed into empty queue with idle FSM at edge N SHALL appear on alu_in after edge N+1 and produce res_valid=1 after edge N+2.
REQ-024 Sustained throughput with res_ready tied high SHALL be one result per 2 cycles.
REQ-025 Opcodes 4..15 SHALL be issued unchanged; res_out is whatever the ALU returns (0); no error flag.
REQ-026 No arithmetic in this block; all widths pass through unmodified.

Reset
REQ-027 On rst_n low: FSM=IDLE, pointers=0, count=0, alu_in=12'h000, res_out=4'h0, res_opcode=4'h0, res_valid=0; instr_ready=1 as a consequence.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight instructions and any pending result; no result SHALL be emitted for them after release.
REQ-029 FIFO storage contents need not be reset.

Verification
REQ-030 Push 12'h134 (add, a=3, b=4), res_ready=1 -> alu_in=12'h134 after N+1; res_valid=1, res_out=4'h7, res_opcode=4'h1 after N+2.
REQ-031 Push 12'h225 (sub, a=2, b=5) -> res_out=4'hD; push 12'h0A5 (xor) -> res_out=4'hF; push 12'h3C7 -> res_out=4'hC; push 12'h9FF -> res_out=4'h0, res_opcode=4'h9.
REQ-032 res_ready=0, six back-to-back pushes with DEPTH=4 -> exactly five accepted, count=4, instr_ready=0, sixth held; results then drain in push order once res_ready=1.
REQ-033 Hold res_ready=0 for 10 cycles with res_valid=1 -> res_out/res_opcode unchanged; raise res_ready -> next result within 2 cycles.
REQ-034 Full FIFO, pop and push offered same cycle -> push refused, count drops to DEPTH-1, push accepted next cycle.
REQ-035 Assert rst_n=0 between edges while in HOLD with count=3 -> outputs reach reset values immediately; after release no result appears without new pushes.
